// File: rtl/uart_pkg.sv
// Shared UART types: parity selection and receiver state encoding.
package uart_pkg;

  typedef enum logic [1:0] {
    PARITY_NONE,
    PARITY_EVEN,
    PARITY_ODD
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } rx_state_t;

  // Counter width for a tick count, never narrower than one bit.
  function automatic int tick_width(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values simply walk the input down the two-stage chain.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, reset to the line's idle level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with held-word handshake, parity/framing
// error flags and an overrun pulse when a finished frame cannot be stored.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line idle, waiting for a falling edge of rx_s
// START | counting to mid start bit; reject if the line went back high
// DATA  | sampling DATA_BITS data bits at mid bit, LSB first
// PAR   | sampling the parity bit (only when PARITY != PARITY_NONE)
// STOP  | sampling STOP_BITS stop bits; frame completes on the last one
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int      CLK_SPEED = 50_000_000,
  parameter int      BAUD_RATE = 9600,
  parameter int      DATA_BITS = 8,
  parameter parity_t PARITY    = PARITY_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BAUD_TICK = CLK_SPEED / BAUD_RATE;
  localparam int HALF_TICK = BAUD_TICK / 2;
  localparam int CNT_W     = tick_width(BAUD_TICK);
  localparam int BIT_W     = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BAUD_TICK - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TICK - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             HAS_PAR   = (PARITY != PARITY_NONE);
  localparam logic             ODD_PAR   = (PARITY == PARITY_ODD);

  // Reject illegal configurations while elaborating.
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_param: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_param: STOP_BITS must be 1 or 2");
  end
  if (BAUD_TICK < 2) begin : g_bad_baud
    $error("uart_rx_param: CLK_SPEED/BAUD_RATE must be at least 2");
  end

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_acc_q, perr_acc_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic                 rx_prev_q, rx_prev_d;

  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;

  logic                 frame_done;
  logic                 frame_ferr;

  // Receiver FSM: next state, bit timing, shift register and error accumulation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shift_d    = shift_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    rx_prev_d  = rx_s;
    frame_done = 1'b0;
    frame_ferr = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d    = DATA;
            bit_d      = '0;
            stop_d     = 1'b0;
            perr_acc_d = 1'b0;
            ferr_acc_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = HAS_PAR ? PAR : STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PAR: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d      = '0;
          // Even: error when data plus parity has odd weight; odd inverts that.
          perr_acc_d = (^shift_q) ^ rx_s ^ ODD_PAR;
          state_d    = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d      = '0;
          ferr_acc_d = ferr_acc_q | ~rx_s;
          if (stop_q == STOP_LAST) begin
            frame_done = 1'b1;
            frame_ferr = ferr_acc_q | ~rx_s;
            stop_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output holding register: load on completion if free or being drained, else flag overrun.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = 1'b0;

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    if (frame_done) begin
      if (!valid_q || data_ready) begin
        data_d  = shift_q;
        perr_d  = HAS_PAR & perr_acc_q;
        ferr_d  = frame_ferr;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // Receiver state and timing registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shift_q    <= '0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      rx_prev_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shift_q    <= shift_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      rx_prev_q  <= rx_prev_d;
    end
  end

  // Output registers seen by the consumer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: three configurations (8N1, 8E1, 7O2),
// expected words queued when a frame is sent and checked when accepted.
module tb_uart_rx_param;
  import uart_pkg::*;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clock = 1'b0;
  logic rst_a_n, rst_b_n, rst_c_n;
  logic rx_a, rx_b, rx_c;
  logic ready_a, ready_b, ready_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic valid_a, valid_b, valid_c;
  logic perr_a, perr_b, perr_c;
  logic ferr_a, ferr_b, ferr_c;
  logic ovr_a, ovr_b, ovr_c;

  int total = 0;
  int bad = 0;
  int vcyc_a = 0;
  int ovr_cnt_a = 0;
  int ovr_cnt_bc = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  exp_t e_a, e_b, e_c;

  always #5 clock = ~clock;

  uart_rx_param #(.CLK_SPEED(16), .BAUD_RATE(1), .DATA_BITS(8),
                  .PARITY(PARITY_NONE), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset_n(rst_a_n), .rx(rx_a), .data_out(data_a),
    .data_valid(valid_a), .data_ready(ready_a), .parity_err(perr_a),
    .frame_err(ferr_a), .overrun(ovr_a));

  uart_rx_param #(.CLK_SPEED(16), .BAUD_RATE(1), .DATA_BITS(8),
                  .PARITY(PARITY_EVEN), .STOP_BITS(1)) dut_b (
    .clock(clock), .reset_n(rst_b_n), .rx(rx_b), .data_out(data_b),
    .data_valid(valid_b), .data_ready(ready_b), .parity_err(perr_b),
    .frame_err(ferr_b), .overrun(ovr_b));

  uart_rx_param #(.CLK_SPEED(16), .BAUD_RATE(1), .DATA_BITS(7),
                  .PARITY(PARITY_ODD), .STOP_BITS(2)) dut_c (
    .clock(clock), .reset_n(rst_c_n), .rx(rx_c), .data_out(data_c),
    .data_valid(valid_c), .data_ready(ready_c), .parity_err(perr_c),
    .frame_err(ferr_c), .overrun(ovr_c));

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
    total++;
    assert (obs === exp_v)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
  endtask

  task automatic hold_bit(input int d, input logic v, input int n);
    case (d)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input int d, input logic [8:0] data, input int nbits,
                      input bit use_par, input logic par_bit,
                      input int nstop, input logic stop_val);
    hold_bit(d, 1'b0, 16);
    for (int i = 0; i < nbits; i++) hold_bit(d, data[i], 16);
    if (use_par) hold_bit(d, par_bit, 16);
    for (int i = 0; i < nstop; i++) hold_bit(d, stop_val, 16);
    hold_bit(d, 1'b1, 16);
  endtask

  // Scoreboard consumers: compare each accepted word against the queue head.
  always @(negedge clock) begin
    if (ovr_a) ovr_cnt_a++;
    if (valid_a) vcyc_a++;
    if (valid_a && ready_a) begin
      chk("a_expect_pending", 9'(q_a.size() != 0), 9'd1);
      if (q_a.size() != 0) begin
        e_a = q_a.pop_front();
        chk("a_data", {1'b0, data_a}, e_a.data);
        chk("a_perr", {8'b0, perr_a}, {8'b0, e_a.perr});
        chk("a_ferr", {8'b0, ferr_a}, {8'b0, e_a.ferr});
      end
    end
  end

  always @(negedge clock) begin
    if (ovr_b || ovr_c) ovr_cnt_bc++;
    if (valid_b && ready_b) begin
      chk("b_expect_pending", 9'(q_b.size() != 0), 9'd1);
      if (q_b.size() != 0) begin
        e_b = q_b.pop_front();
        chk("b_data", {1'b0, data_b}, e_b.data);
        chk("b_perr", {8'b0, perr_b}, {8'b0, e_b.perr});
        chk("b_ferr", {8'b0, ferr_b}, {8'b0, e_b.ferr});
      end
    end
    if (valid_c && ready_c) begin
      chk("c_expect_pending", 9'(q_c.size() != 0), 9'd1);
      if (q_c.size() != 0) begin
        e_c = q_c.pop_front();
        chk("c_data", {2'b0, data_c}, e_c.data);
        chk("c_perr", {8'b0, perr_c}, {8'b0, e_c.perr});
        chk("c_ferr", {8'b0, ferr_c}, {8'b0, e_c.ferr});
      end
    end
  end

  initial begin
    int v0;
    int o0;
    logic [8:0] r;

    rst_a_n = 1'b0; rst_b_n = 1'b0; rst_c_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_a_data", {1'b0, data_a}, 9'h000);
    chk("rst_a_valid", {8'b0, valid_a}, 9'h000);
    chk("rst_a_perr", {8'b0, perr_a}, 9'h000);
    chk("rst_a_ferr", {8'b0, ferr_a}, 9'h000);
    chk("rst_a_overrun", {8'b0, ovr_a}, 9'h000);
    chk("rst_a_state", 9'(dut_a.state_q), 9'(IDLE));
    chk("rst_c_valid", {8'b0, valid_c}, 9'h000);
    rst_a_n = 1'b1; rst_b_n = 1'b1; rst_c_n = 1'b1;
    hold_bit(0, 1'b1, 8);

    // 8N1 basic word, valid for exactly one cycle while ready is high
    v0 = vcyc_a;
    q_a.push_back('{data: 9'h0A5, perr: 1'b0, ferr: 1'b0});
    send(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("a_valid_one_cycle", 9'(vcyc_a - v0), 9'd1);

    // 8N1 extreme and random patterns
    q_a.push_back('{data: 9'h000, perr: 1'b0, ferr: 1'b0});
    send(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b1);
    q_a.push_back('{data: 9'h0FF, perr: 1'b0, ferr: 1'b0});
    send(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      r = 9'($urandom_range(0, 255));
      q_a.push_back('{data: r, perr: 1'b0, ferr: 1'b0});
      send(0, r, 8, 1'b0, 1'b0, 1, 1'b1);
    end

    // 8E1 parity: 0x03 has even weight, so parity bit 1 is an error
    q_b.push_back('{data: 9'h003, perr: 1'b1, ferr: 1'b0});
    send(1, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1);
    q_b.push_back('{data: 9'h003, perr: 1'b0, ferr: 1'b0});
    send(1, 9'h003, 8, 1'b1, 1'b0, 1, 1'b1);
    q_b.push_back('{data: 9'h080, perr: 1'b0, ferr: 1'b0});
    send(1, 9'h080, 8, 1'b1, 1'b1, 1, 1'b1);
    q_b.push_back('{data: 9'h080, perr: 1'b1, ferr: 1'b0});
    send(1, 9'h080, 8, 1'b1, 1'b0, 1, 1'b1);

    // 8N1 framing error, then a 40 bit-time break yielding one frame
    q_a.push_back('{data: 9'h03C, perr: 1'b0, ferr: 1'b1});
    send(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b0);
    q_a.push_back('{data: 9'h000, perr: 1'b0, ferr: 1'b1});
    hold_bit(0, 1'b0, 40 * 16);
    hold_bit(0, 1'b1, 32);
    chk("break_one_frame", 9'(q_a.size()), 9'd0);

    // Short low glitch in IDLE is rejected
    v0 = vcyc_a;
    hold_bit(0, 1'b0, 4);
    hold_bit(0, 1'b1, 24);
    chk("glitch_no_valid", 9'(vcyc_a - v0), 9'd0);
    chk("glitch_idle", 9'(dut_a.state_q), 9'(IDLE));

    // Overrun: consumer stalled, second word dropped, first kept
    ready_a = 1'b0;
    o0 = ovr_cnt_a;
    q_a.push_back('{data: 9'h011, perr: 1'b0, ferr: 1'b0});
    send(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
    send(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
    chk("ovr_held_data", {1'b0, data_a}, 9'h011);
    chk("ovr_held_valid", {8'b0, valid_a}, 9'h001);
    chk("ovr_pulse_count", 9'(ovr_cnt_a - o0), 9'd1);
    ready_a = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("ovr_valid_drop", {8'b0, valid_a}, 9'h000);

    // 7O2: reset in the middle of the data bits, then a clean frame
    @(posedge clock);
    #1;
    hold_bit(2, 1'b0, 16);
    hold_bit(2, 1'b0, 16);
    hold_bit(2, 1'b1, 16);
    hold_bit(2, 1'b0, 8);
    rst_c_n = 1'b0;
    rx_c = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("c_rst_data", {2'b0, data_c}, 9'h000);
    chk("c_rst_valid", {8'b0, valid_c}, 9'h000);
    chk("c_rst_state", 9'(dut_c.state_q), 9'(IDLE));
    rst_c_n = 1'b1;
    hold_bit(2, 1'b1, 32);
    q_c.push_back('{data: 9'h05A, perr: 1'b0, ferr: 1'b0});
    send(2, 9'h05A, 7, 1'b1, 1'b1, 2, 1'b1);
    q_c.push_back('{data: 9'h05A, perr: 1'b1, ferr: 1'b0});
    send(2, 9'h05A, 7, 1'b1, 1'b0, 2, 1'b1);

    repeat (20) @(posedge clock);
    #1;
    chk("a_queue_drained", 9'(q_a.size()), 9'd0);
    chk("b_queue_drained", 9'(q_b.size()), 9'd0);
    chk("c_queue_drained", 9'(q_c.size()), 9'd0);
    chk("bc_no_overrun", 9'(ovr_cnt_bc), 9'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter CLK_SPEED, default 50_000_000: clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 9600: line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter PARITY, default PARITY_NONE: one of PARITY_NONE, PARITY_EVEN, PARITY_ODD.
REQ-005 SHALL have parameter STOP_BITS, default 1: stop bits checked per frame, 1 or 2.
REQ-006 SHALL have port clock, input, 1: rising-edge clock.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port rx, input, 1: asynchronous serial line, idle high.
REQ-009 SHALL have port data_out, output, DATA_BITS: received word, LSB first on the line.
REQ-010 SHALL have port data_valid, output, 1: data_out, parity_err and frame_err are valid.
REQ-011 SHALL have port data_ready, input, 1: consumer accepts the word.
REQ-012 SHALL have port parity_err, output, 1: parity mismatch on the held word.
REQ-013 SHALL have port frame_err, output, 1: a stop bit was sampled low on the held word.
REQ-014 SHALL have port overrun, output, 1: one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL derive BAUD_TICK = CLK_SPEED/BAUD_RATE and HALF_TICK = BAUD_TICK/2 by integer division, with the tick counter sized $clog2(BAUD_TICK).
REQ-016 SHALL pass rx through a two-flop synchroniser (rx_s) that resets to 1; all decisions use rx_s only.
REQ-017 SHALL implement states IDLE, START, DATA, PAR, STOP.
REQ-018 IDLE SHALL go to START with the tick counter cleared on a falling edge of rx_s (previous rx_s 1, current 0).
REQ-019 START SHALL, at tick HALF_TICK-1, go to DATA with the counter cleared if rx_s==0, else return to IDLE (glitch reject).
REQ-020 DATA SHALL sample rx_s at tick BAUD_TICK-1, shift it in at the MSB end (LSB first), and clear the counter.
REQ-021 After DATA_BITS samples, DATA SHALL go to PAR if PARITY!=PARITY_NONE, else to STOP.
REQ-022 PAR SHALL sample one bit at tick BAUD_TICK-1; error when data XOR parity bit is 1 (EVEN) or 0 (ODD).
REQ-023 STOP SHALL sample STOP_BITS bits at tick BAUD_TICK-1 each, with frame error if any sample is 0.
REQ-024 The frame SHALL complete on the last stop sample, and the FSM SHALL return to IDLE in the same cycle.
REQ-025 On completion with data_valid==0, or data_valid&&data_ready in that same cycle, the block SHALL register word and error flags and assert data_valid the next cycle.
REQ-026 On completion with data_valid&&!data_ready, the block SHALL keep the held word and flags and pulse overrun for exactly one cycle.
REQ-027 data_valid SHALL stay high with data_out, parity_err and frame_err stable until a cycle with data_ready==1, then deassert unless reloaded per REQ-025.
REQ-028 parity_err SHALL be 0 when PARITY==PARITY_NONE.
REQ-029 A line held low (break) SHALL produce at most one frame, with frame_err=1, and no new START until rx_s returns high.

Reset
REQ-030 reset_n low SHALL asynchronously force IDLE, counters 0, shift register 0, synchroniser flops 1, data_out 0, data_valid 0, parity_err 0, frame_err 0, overrun 0.
REQ-031 Reset mid-frame SHALL discard the partial frame, and the next full frame SHALL be received normally.

Structure
REQ-032 Package uart_pkg SHALL hold the parity_t enum (PARITY_NONE, PARITY_EVEN, PARITY_ODD) and the rx state enum.
REQ-033 The two-flop synchroniser SHALL be a sub-module uart_sync2, reused by future UART blocks.
REQ-034 Legal ranges of DATA_BITS and STOP_BITS SHALL be checked at elaboration.

Verification (CLK_SPEED=16, BAUD_RATE=1, so BAUD_TICK=16)
REQ-035 8N1, send 0xA5, data_ready=1 -> data_out=0xA5, data_valid high for one cycle, no errors.
REQ-036 8E1, send 0x03 with parity bit 1 -> data_out=0x03, parity_err=1; with parity bit 0 -> parity_err=0.
REQ-037 8N1, send 0x3C with stop bit 0 -> frame_err=1, data_out=0x3C; line low 40 bit times -> exactly one frame.
REQ-038 rx low for 4 clocks in IDLE -> no data_valid, FSM back in IDLE.
REQ-039 data_ready=0, send 0x11 then 0x22 -> data_out stays 0x11, one overrun pulse; data_ready=1 -> 0x11 accepted, data_valid drops.
REQ-040 DATA_BITS=7, STOP_BITS=2, ODD: reset_n pulsed mid-DATA, then send 0x5A -> data_out=0x5A, no errors.
